// File: rtl/cnn_pkg.sv
// cnn_pkg: shared image/window geometry, widths and FSM encoding for the CNN front end
// Exports IMG_W/IMG_H/K/PIX_W, WIN_N, FRAME_PIX, CW/AW widths, ST_LOAD/ST_SCAN and pix_addr().
package cnn_pkg;
   localparam int IMG_W = 28;
   localparam int IMG_H = 28;
   localparam int K = 5;
   localparam int PIX_W = 8;
   localparam int WIN_N = IMG_W - K + 1;
   localparam int FRAME_PIX = IMG_W * IMG_H;
   localparam int CW = 5;
   localparam int AW = 10;
   localparam int WIN_BITS = K * K * PIX_W;
   localparam logic [0:0] ST_LOAD = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;
   localparam logic [CW-1:0] LAST_ORG = CW'(WIN_N - 1);
   localparam logic [AW-1:0] LAST_PIX = AW'(FRAME_PIX - 1);
   function automatic logic [AW-1:0] pix_addr(input logic [CW-1:0] x, input logic [CW-1:0] y);
      return AW'(x) * AW'(IMG_W) + AW'(y);
   endfunction
endpackage

// File: rtl/img_buf.sv
// img_buf: one-frame pixel store with a single write port and K*K combinational window taps
// clk/we/waddr/wdata: write port; org_x/org_y: window origin (row, column); taps: packed window, byte i*K+j.
module img_buf
   import cnn_pkg::*;
(
   input  logic                clk,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [PIX_W-1:0]    wdata,
   input  logic [CW-1:0]       org_x,
   input  logic [CW-1:0]       org_y,
   output logic [WIN_BITS-1:0] taps
);
   logic [PIX_W-1:0] mem [FRAME_PIX];
   logic [AW-1:0] base;
   assign base = pix_addr(org_x, org_y);
   always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
   for (genvar i = 0; i < K; i++) begin : g_r
      for (genvar j = 0; j < K; j++) begin : g_c
         // origin is at most (23,23), so base + offset never exceeds 783
         assign taps[(i*K+j)*PIX_W +: PIX_W] = mem[base + AW'(i*IMG_W + j)];
      end
   end
endmodule

// File: rtl/window_gen.sv
// window_gen: loads a 28x28 pixel stream, then streams every 5x5 window with its origin
// PIX_IN/PIX_VALID/PIX_READY: row-major pixel input; WIN_DATA/WIN_X/WIN_Y/WIN_VALID/WIN_READY: window output;
// FRAME_DONE: pulse after the last window is accepted; BUSY: scanning.
module window_gen
   import cnn_pkg::*;
(
   input  logic                CLK,
   input  logic                RST,
   input  logic [PIX_W-1:0]    PIX_IN,
   input  logic                PIX_VALID,
   output logic                PIX_READY,
   output logic [WIN_BITS-1:0] WIN_DATA,
   output logic [CW-1:0]       WIN_X,
   output logic [CW-1:0]       WIN_Y,
   output logic                WIN_VALID,
   input  logic                WIN_READY,
   output logic                FRAME_DONE,
   output logic                BUSY
);
   logic [0:0] state;
   logic [AW-1:0] pix_cnt;
   logic [CW-1:0] nx, ny;
   logic [WIN_BITS-1:0] taps;
   logic pix_acc, last_pix, win_acc, y_wrap, last_win;
   assign PIX_READY = state == ST_LOAD;
   assign BUSY = state == ST_SCAN;
   assign pix_acc = PIX_VALID & PIX_READY;
   assign last_pix = pix_acc & (pix_cnt == LAST_PIX);
   assign win_acc = BUSY & WIN_VALID & WIN_READY;
   assign y_wrap = WIN_Y == LAST_ORG;
   assign last_win = win_acc & y_wrap & (WIN_X == LAST_ORG);
   // next origin; after the final window it returns to (0,0) so the taps stay in range
   assign ny = win_acc ? (y_wrap ? '0 : WIN_Y + CW'(1)) : WIN_Y;
   assign nx = (win_acc & y_wrap) ? ((WIN_X == LAST_ORG) ? '0 : WIN_X + CW'(1)) : WIN_X;
   img_buf u_buf (
      .clk   (CLK),
      .we    (pix_acc),
      .waddr (pix_cnt),
      .wdata (PIX_IN),
      .org_x (nx),
      .org_y (ny),
      .taps  (taps)
   );
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_LOAD;
         pix_cnt <= '0;
         WIN_X <= '0;
         WIN_Y <= '0;
         WIN_VALID <= 1'b0;
         WIN_DATA <= '0;
         FRAME_DONE <= 1'b0;
      end else begin
         FRAME_DONE <= last_win;
         WIN_X <= nx;
         WIN_Y <= ny;
         if (pix_acc) pix_cnt <= last_pix ? '0 : pix_cnt + AW'(1);
         if (last_pix) begin
            state <= ST_SCAN;
            WIN_VALID <= 1'b1;
         end
         if (last_win) begin
            state <= ST_LOAD;
            WIN_VALID <= 1'b0;
         end
         if (last_pix | win_acc) WIN_DATA <= taps;
      end
   end
endmodule
